result_serializer: RTL

//  Parametrised result-to-UART byte serializer. Captures one DATA_W-bit result word
//  on a valid/ready handshake and holds it. Sends the word as DATA_W/8 bytes to the

---
 rtl/result_serializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/result_serializer.sv
// Purpose: captures one DATA_W-bit result word and streams it to uart_tx as DATA_W/8 bytes.
// Latency: capture -> first tx_start 2 cycles; tx_done -> next tx_start 2 cycles; last tx_done -> frame_done 2 cycles.
// Backpressure: in_ready is low for the whole frame; tx_start waits in START while tx_busy is high.
module result_serializer #(
  parameter int DATA_W    = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DATA_W-1:0] held_data,
  output logic              frame_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NB - 1);

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
      $error("result_serializer: DATA_W must be a non-zero multiple of 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, WAIT, FIN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  sel;
  logic [DATA_W-1:0] held_d;
  logic [7:0]        tx_data_d;
  logic              tx_start_d;
  logic              frame_done_d;

  // Only the idle state may take a new word.
  assign in_ready = (state_q == IDLE);

  // Map the send position onto a byte lane of the held word.
  always_comb begin
    sel = MSB_FIRST ? (LAST - idx_q) : idx_q;
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    held_d       = held_data;
    tx_data_d    = tx_data;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          held_d  = in_data;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = 8'(held_data >> {sel, 3'b000});
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = START;
          end
        end
      end
      FIN: begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      held_data  <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      held_data  <= held_d;
      tx_data    <= tx_data_d;
      tx_start   <= tx_start_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
